// File: rtl/rom_loader_if.sv
// rom_loader_if: command, byte-stream and ROM loader-port signals of rom_loader.
interface rom_loader_if #(parameter int ADDR_W = 16);
  logic              cmd_start;
  logic [ADDR_W-1:0] cmd_base;
  logic [ADDR_W:0]   cmd_len;
  logic              cmd_abort;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              loader_act;
  logic [ADDR_W-1:0] loader_a;
  logic [7:0]        loader_d;
  logic              loader_wr;
  logic              busy;
  logic              done;
  logic [7:0]        csum;
  modport master (
    output cmd_start, cmd_base, cmd_len, cmd_abort, in_data, in_valid,
    input  in_ready, loader_act, loader_a, loader_d, loader_wr, busy, done, csum
  );
  modport slave (
    input  cmd_start, cmd_base, cmd_len, cmd_abort, in_data, in_valid,
    output in_ready, loader_act, loader_a, loader_d, loader_wr, busy, done, csum
  );
endinterface

// File: rtl/rom_loader.sv
// rom_loader: streams bytes into the boot ROM loader port with auto-incrementing address.
// Optional checksum output is built only when ROM_LOADER_CSUM_EN is defined.
module rom_loader #(parameter int ADDR_W = 16) (
  input  logic         clk,
  input  logic         rst_n,
  rom_loader_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LOAD, TAIL, FIN} state_e;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, la_q, la_d;
  logic [ADDR_W:0]   remain_q, remain_d;
  logic [7:0]        ld_q, ld_d;
  logic              wr_q, wr_d, act_q, act_d, done_q, done_d;
  logic              accept, go;
  assign bus.in_ready   = state_q == LOAD && !bus.cmd_abort;
  assign accept         = bus.in_ready && bus.in_valid;
  assign go             = state_q == IDLE && bus.cmd_start && !bus.cmd_abort;
  assign bus.loader_act = act_q;
  assign bus.loader_a   = la_q;
  assign bus.loader_d   = ld_q;
  assign bus.loader_wr  = wr_q;
  assign bus.busy       = state_q != IDLE;
  assign bus.done       = done_q;
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    la_d     = la_q;
    ld_d     = ld_q;
    wr_d     = accept;
    done_d   = 1'b0;
    if (bus.cmd_abort) state_d = IDLE;
    else case (state_q)
      IDLE: if (go) begin
        done_d   = bus.cmd_len == '0;
        state_d  = bus.cmd_len == '0 ? IDLE : LOAD;
        addr_d   = bus.cmd_base;
        remain_d = bus.cmd_len;
      end
      LOAD: if (accept) begin
        la_d     = addr_q;
        ld_d     = bus.in_data;
        addr_d   = addr_q + ADDR_W'(1);
        remain_d = remain_q - (ADDR_W+1)'(1);
        state_d  = remain_q == (ADDR_W+1)'(1) ? TAIL : LOAD;
      end
      TAIL: begin
        state_d = FIN;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // FIN keeps the port owned for one cycle after the final strobe
    act_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      la_q     <= '0;
      ld_q     <= '0;
      wr_q     <= 1'b0;
      act_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      la_q     <= la_d;
      ld_q     <= ld_d;
      wr_q     <= wr_d;
      act_q    <= act_d;
      done_q   <= done_d;
    end
`ifdef ROM_LOADER_CSUM_EN
  logic [7:0] csum_q, csum_d;
  assign csum_d   = go && bus.cmd_len != '0 ? 8'h00 : accept ? csum_q + bus.in_data : csum_q;
  assign bus.csum = csum_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) csum_q <= 8'h00;
    else csum_q <= csum_d;
`else
  assign bus.csum = 8'h00;
`endif
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: randomized sessions checked against a transaction-level model of rom_loader.
module tb_rom_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  logic [15:0] last_a = 16'h0000;
  logic [7:0]  last_d = 8'h00;
`ifdef ROM_LOADER_CSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  rom_loader_if #(.ADDR_W(16)) bus();
  rom_loader #(.ADDR_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_act"}, bus.loader_act, 0);
    chk({tag, "_wr"}, bus.loader_wr, 0);
    chk({tag, "_rdy"}, bus.in_ready, 0);
    chk({tag, "_a"}, bus.loader_a, last_a);
    chk({tag, "_d"}, bus.loader_d, last_d);
  endtask
  // vmode: 0 continuous, 1 alternating 1/0, 2 random gaps; dmode: 0 random, 1 0x11*n, 2 0xA0+n
  task automatic session(input logic [15:0] base, input logic [16:0] len, input int vmode,
                         input int dmode, input int abort_at, input bit poke);
    int acc, cyc;
    logic [15:0] a;
    logic [7:0] d, sum;
    bit took;
    acc = 0;
    cyc = 0;
    a = base;
    sum = 8'h00;
    bus.cmd_base = base;
    bus.cmd_len = len;
    bus.cmd_start = 1'b1;
    #1 chk("idle_rdy", bus.in_ready, 0);
    @(negedge clk);
    bus.cmd_start = 1'b0;
    chk("start_busy", bus.busy, len != 0);
    chk("start_act", bus.loader_act, len != 0);
    chk("start_done", bus.done, len == 0);
    chk("start_wr", bus.loader_wr, 0);
    if (len == 0) begin
      @(negedge clk);
      chk("zlen_done", bus.done, 0);
      idle_chk("zlen");
      return;
    end
    chk("start_csum", bus.csum, 0);
    while (acc < int'(len) && cyc < 2000) begin
      bus.in_valid = vmode == 0 ? 1'b1 : vmode == 1 ? (cyc % 2 == 0) : ($urandom_range(99) >= 30);
      bus.in_data = dmode == 1 ? 8'(8'h11 * (acc + 1)) : dmode == 2 ? 8'(8'hA0 + acc) : 8'($urandom);
      bus.cmd_abort = acc == abort_at;
      if (bus.cmd_abort) bus.in_valid = 1'b1;
      if (poke) begin
        bus.cmd_start = 1'($urandom);
        bus.cmd_base = 16'($urandom);
        bus.cmd_len = 17'($urandom);
      end
      #1 chk("in_ready", bus.in_ready, !bus.cmd_abort);
      took = bus.in_valid && !bus.cmd_abort;
      d = bus.in_data;
      cyc++;
      @(negedge clk);
      bus.cmd_start = 1'b0;
      chk("wr", bus.loader_wr, took);
      if (took) begin
        last_a = a;
        last_d = d;
        a = a + 16'd1;
        acc++;
        sum = sum + d;
      end
      chk("addr", bus.loader_a, last_a);
      chk("data", bus.loader_d, last_d);
      chk("csum", bus.csum, CS ? sum : 8'h00);
      if (bus.cmd_abort) begin
        bus.cmd_abort = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_act", bus.loader_act, 0);
        chk("abort_done", bus.done, 0);
        @(negedge clk);
        idle_chk("post_abort");
        chk("post_abort_done", bus.done, 0);
        return;
      end
      chk("busy", bus.busy, 1);
      chk("act", bus.loader_act, 1);
      chk("done", bus.done, 0);
    end
    if (acc < int'(len)) begin
      chk("budget", acc, len);
      bus.cmd_abort = 1'b1;
      @(negedge clk);
      bus.cmd_abort = 1'b0;
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_data = 8'($urandom);
    #1 chk("tail_rdy", bus.in_ready, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("fin_done", bus.done, 1);
    chk("fin_act", bus.loader_act, 1);
    chk("fin_busy", bus.busy, 1);
    chk("fin_wr", bus.loader_wr, 0);
    chk("fin_a", bus.loader_a, last_a);
    chk("fin_d", bus.loader_d, last_d);
    @(negedge clk);
    idle_chk("end");
    chk("end_done", bus.done, 0);
    chk("end_csum", bus.csum, CS ? sum : 8'h00);
  endtask
  task automatic reset_mid;
    bus.cmd_base = 16'h2000;
    bus.cmd_len = 17'd5;
    bus.cmd_start = 1'b1;
    @(negedge clk);
    bus.cmd_start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h5A;
    @(negedge clk);
    bus.in_data = 8'h3C;
    @(negedge clk);
    chk("rst_pre_wr", bus.loader_wr, 1);
    chk("rst_pre_a", bus.loader_a, 16'h2001);
    #3 rst_n = 1'b0;
    #1;
    last_a = 16'h0000;
    last_d = 8'h00;
    idle_chk("rst_async");
    chk("rst_async_done", bus.done, 0);
    chk("rst_async_csum", bus.csum, 0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idle_chk("post_rst");
    chk("post_rst_csum", bus.csum, 0);
  endtask
  initial begin
    bus.cmd_start = 1'b0;
    bus.cmd_base = 16'h0000;
    bus.cmd_len = 17'd0;
    bus.cmd_abort = 1'b0;
    bus.in_data = 8'h00;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    idle_chk("reset");
    chk("reset_done", bus.done, 0);
    chk("reset_csum", bus.csum, 0);
    rst_n = 1'b1;
    @(negedge clk);
    idle_chk("idle");
    session(16'h0000, 17'd0, 0, 0, -1, 1'b0);
    session(16'h1000, 17'd4, 0, 1, -1, 1'b0);
    chk("csum_aa", bus.csum, CS ? 8'hAA : 8'h00);
    session(16'hFFFE, 17'd4, 1, 2, -1, 1'b0);
    session(16'h3000, 17'd8, 0, 0, 3, 1'b0);
    session(16'h4000, 17'd6, 2, 0, -1, 1'b1);
    reset_mid;
    session(16'h5000, 17'd5, 2, 0, -1, 1'b0);
    repeat (25)
      session(16'($urandom), 17'($urandom_range(40, 1)), int'($urandom_range(2)), 0,
              $urandom_range(3) == 0 ? int'($urandom_range(10)) : -1, 1'($urandom_range(1)));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rom_loader.md
# rom_loader

Write-side sequencer for the 64 KiB boot ROM's loader port. Accepts a load command (base address, byte count) from the host/MCU link, then converts a valid/ready byte stream into one-byte-per-cycle `loader_act`/`loader_a`/`loader_d`/`loader_wr` writes with auto-incrementing address. Sits between the MCU/SPI command decoder and the ROM. Owns `loader_act` for the duration of a load.

## Interface
Parameters:
- `ADDR_W`, 16: ROM address width. Byte count is `ADDR_W+1` bits.

Ports:
- `clk`  in  1  system clock. All logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_start`  in  1  one-cycle pulse: begin a load session. Sampled only in IDLE.
- `cmd_base`  in  16  first ROM address. Sampled with `cmd_start`.
- `cmd_len`  in  17  byte count, 0..65536. Sampled with `cmd_start`.
- `cmd_abort`  in  1  level/pulse: terminate the session immediately.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  block accepts a byte this cycle.
- `loader_act`  out  1  loader owns the ROM write port.
- `loader_a`  out  16  write address.
- `loader_d`  out  8  write data.
- `loader_wr`  out  1  write strobe, one cycle per byte.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse on normal completion.
- `csum`  out  8  running byte checksum (see Configuration).

## Operation
- States: IDLE, LOAD, TAIL, FIN.
- IDLE: `loader_act`=0, `in_ready`=0. On `cmd_start`:
  - `cmd_len`==0: `done` pulses the next cycle. State stays IDLE. No write.
  - Otherwise: latch `addr`=`cmd_base` and `remain`=`cmd_len`. Clear `csum`. Go to LOAD.
- LOAD: `loader_act`=1 and `in_ready`=1.
  - Accept = `in_valid & in_ready`.
  - On each accept: register `loader_d`=`in_data` and `loader_a`=`addr`, and assert `loader_wr` for the next cycle only. Then `addr`++ (wraps 0xFFFF→0x0000) and `remain`--.
  - On the accept where `remain`==1: go to TAIL. `in_ready` is 0 from the next cycle.
- TAIL: the last write strobe is on the outputs. Go to FIN.
- FIN: `loader_act`=1, `loader_wr`=0, `done`=1. Go to IDLE.
- `cmd_start` outside IDLE: ignored.
- `cmd_abort` in any non-IDLE state:
  - Next state is IDLE. No `done`.
  - A byte presented in the same cycle is not accepted (`in_ready` is masked by abort).
  - A write already registered still completes its one-cycle strobe.
- `cmd_abort` takes priority over `cmd_start` in the same cycle.
- `in_valid` gaps: allowed. No write is issued and state is unchanged.
- `loader_a`/`loader_d` hold their last values when `loader_wr`=0.

## Timing
- All outputs are registered except `in_ready`, which is decoded from state and `cmd_abort`.
- Reset values: `in_ready`=0, `loader_act`=0, `loader_a`=0x0000, `loader_d`=0x00, `loader_wr`=0, `busy`=0, `done`=0, `csum`=0x00. State is IDLE.
- `cmd_start` at edge N → `busy`=1 and `loader_act`=1 from cycle N+1. `in_ready`=1 in cycle N+1.
- Byte accepted at edge K → `loader_wr`=1 in cycle K+1, with the matching `loader_a`/`loader_d`.
- Throughput: 1 byte/cycle with continuous `in_valid`.
- Last byte accepted at edge K:
  - Cycle K+1: `loader_wr`=1 (TAIL).
  - Cycle K+2: `done`=1 and `loader_act`=1 (FIN).
  - Cycle K+3: `loader_act`=0 and `busy`=0.
- `loader_act` stays high for at least one cycle after the final `loader_wr`. The ROM write therefore lands while the port is still owned.
- Reset asserted mid-load: all outputs go to their reset values immediately. No partial `done`.

## Configuration
- `ROM_LOADER_CSUM_EN` defined:
  - `csum` = 8-bit sum mod 256 of all accepted bytes.
  - Cleared on session start.
  - Updated on the cycle `loader_wr` asserts for that byte.
  - Holds its value after `done` until the next `cmd_start`.
- Not defined: `csum` is tied to 0x00 and the adder is not built. All other behaviour is identical.

## Test plan
- Reset, then idle: all outputs at reset values. `cmd_start` with `cmd_len`=0 → `done` pulse one cycle later. `loader_act` never 1 and no `loader_wr`.
- `cmd_base`=0x1000, `cmd_len`=4, bytes 0x11,0x22,0x33,0x44 streamed back-to-back → writes to 0x1000..0x1003 on 4 consecutive cycles. `done` 2 cycles after the last accept. `csum`=0xAA with the macro, 0x00 without.
- `cmd_base`=0xFFFE, `cmd_len`=4, bytes A0..A3 with `in_valid` toggling 1,0,1,0 → writes at 0xFFFE, 0xFFFF, 0x0000, 0x0001 in order. No write in gap cycles.
- Mid-stream abort: `cmd_len`=8, `cmd_abort` after 3 accepts, with `in_valid`=1 in the abort cycle → exactly 3 writes and no `done`. `busy`=0 the next cycle. A later `cmd_start` works normally.
- `cmd_start` pulsed during LOAD with a different base → ignored. Address sequence continues from the original base.
- `rst_n` asserted mid-load (after 2 writes of 5) → `loader_act`, `loader_wr`, `in_ready` and `busy` drop asynchronously. After release the block is in IDLE with `csum`=0x00.
